// File: rtl/uart_rx_byte_pkg.sv
// rtl/uart_rx_byte_pkg.sv - shared types and helpers for the uart_rx_byte receiver
package uart_rx_byte_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } rx_state_e;

    localparam int MIN_CLKS_PER_BIT = 4;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// rtl/uart_rx_byte_if.sv - received-byte valid/ready handshake between receiver and consumer
interface uart_rx_byte_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_byte_sync_2ff.sv
// rtl/uart_rx_byte_sync_2ff.sv - generic 2-flop synchronizer with a configurable reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {2{RESET_VAL}};
        else     sync_q <= sync_d;
    end

    assign q = sync_q[1];
endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with valid/ready byte output and error pulses
// Define UART_RX_PARITY_EN for an 8E1 frame with a live parity_err.
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    uart_rx_byte_if.master   rx_bus,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun_err,
    output logic             parity_err
);
    localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CPB - CPB / 2);

    if (CPB < MIN_CLKS_PER_BIT) begin : g_cfg_check
        $error("uart_rx_byte: CLK_HZ/BAUD gives fewer than 4 clocks per bit");
    end

    logic rx_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    rx_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           busy_q, busy_d;
    logic           frame_err_q, frame_err_d;
    logic           overrun_err_q, overrun_err_d;
    logic [1:0]     fill_q, fill_d;
    logic           idle_seen_q, idle_seen_d;
    logic           tick;
`ifdef UART_RX_PARITY_EN
    logic           parity_bad_q, parity_bad_d;
    logic           parity_err_q, parity_err_d;
`endif

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        state_d       = state_q;
        cnt_d         = tick ? '0 : cnt_q + CW'(1);
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        // The synchronizer's reset-value ones are not real line samples; only
        // count a high once the chain has been refilled from rx_in.
        fill_d        = {fill_q[0], 1'b1};
        idle_seen_d   = idle_seen_q | (fill_q[1] & rx_s);
`ifdef UART_RX_PARITY_EN
        parity_bad_d  = parity_bad_q;
        parity_err_d  = 1'b0;
`endif

        if (rx_valid_q && rx_bus.rx_ready) rx_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s && idle_seen_q) begin
                    state_d = S_START;
                    cnt_d   = CNT_HALF;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    parity_bad_d = rx_s ^ (^shift_q);
                    state_d      = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                        // A byte being accepted this cycle frees the holding register.
                        if (!rx_valid_q || rx_bus.rx_ready) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_err_d = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        parity_err_d = parity_bad_q;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_BREAK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            fill_q        <= 2'b00;
            idle_seen_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q  <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            busy_q        <= busy_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            fill_q        <= fill_d;
            idle_seen_q   <= idle_seen_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q  <= parity_bad_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign rx_bus.rx_data  = rx_data_q;
    assign rx_bus.rx_valid = rx_valid_q;
    assign busy            = busy_q;
    assign frame_err       = frame_err_q;
    assign overrun_err     = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err      = parity_err_q;
`else
    assign parity_err      = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - directed self-checking bench for uart_rx_byte (10 clk per bit)
`timescale 1ns/1ps
module tb_uart_rx_byte;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_in = 1'b1;
    logic busy, frame_err, overrun_err, parity_err;

    uart_rx_byte_if bus();

    uart_rx_byte #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .rx_bus      (bus),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0;
    int n_rise, n_vcyc, n_acc, n_frame, n_over, n_par, n_par_v, n_busy;
    int rise_cyc, busy_rise_cyc, busy_fall_cyc;
    int n_par_all = 0;
    logic [7:0] last_data, last_acc;
    logic prev_valid = 1'b0;
    logic prev_busy  = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid && !prev_valid) begin
                n_rise++; last_data = bus.rx_data; rise_cyc = cyc;
            end
            if (busy && !prev_busy) busy_rise_cyc = cyc;
            if (!busy && prev_busy) busy_fall_cyc = cyc;
            if (busy) n_busy++;
            if (bus.rx_valid) n_vcyc++;
            if (bus.rx_valid && bus.rx_ready) begin n_acc++; last_acc = bus.rx_data; end
            if (frame_err) n_frame++;
            if (overrun_err) n_over++;
            if (parity_err) begin
                n_par++; n_par_all++;
                if (bus.rx_valid && !prev_valid) n_par_v++;
            end
        end
        prev_valid = bus.rx_valid;
        prev_busy  = busy;
    end

    task automatic clear_mon();
        n_rise = 0; n_vcyc = 0; n_acc = 0; n_frame = 0; n_over = 0;
        n_par = 0; n_par_v = 0; n_busy = 0;
        rise_cyc = -1; busy_rise_cyc = -1; busy_fall_cyc = -1;
        last_data = 8'hxx; last_acc = 8'hxx;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        wait_clk(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
`else
        if (par_flip) rx_in = 1'b1;
`endif
        drive_bit(stop);
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_in = 1'b1; bus.rx_ready = 1'b0;
        wait_clk(3);
        n_checks++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bus.rx_valid); else n_pass++;
        n_checks++; if (bus.rx_data !== 8'h00) $display("FAIL reset_data got %02h want 00", bus.rx_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame got %0b want 0", frame_err); else n_pass++;
        n_checks++; if (overrun_err !== 1'b0) $display("FAIL reset_overrun got %0b want 0", overrun_err); else n_pass++;
        n_checks++; if (parity_err !== 1'b0) $display("FAIL reset_parity got %0b want 0", parity_err); else n_pass++;
        rst = 1'b0;
        wait_clk(8);
    endtask

    task automatic test_single();
        int c0;
        clear_mon();
        bus.rx_ready = 1'b1;
        c0 = cyc;
        send_byte(8'hA5, 1'b1, 1'b0);
        wait_clk(20);
        n_checks++; if (n_rise !== 1) $display("FAIL single_rises got %0d want 1", n_rise); else n_pass++;
        n_checks++; if (last_data !== 8'hA5) $display("FAIL single_data got %02h want a5", last_data); else n_pass++;
        n_checks++; if (n_vcyc !== 1) $display("FAIL single_valid_width got %0d want 1", n_vcyc); else n_pass++;
        n_checks++; if (rise_cyc !== c0 + 98) $display("FAIL single_latency got %0d want %0d", rise_cyc - c0, 98); else n_pass++;
        n_checks++; if (busy_rise_cyc !== c0 + 3) $display("FAIL single_busy_rise got %0d want %0d", busy_rise_cyc - c0, 3); else n_pass++;
        n_checks++; if (busy_fall_cyc !== c0 + 98) $display("FAIL single_busy_fall got %0d want %0d", busy_fall_cyc - c0, 98); else n_pass++;
        n_checks++; if (n_frame + n_over + n_par !== 0) $display("FAIL single_errors got %0d want 0", n_frame + n_over + n_par); else n_pass++;
    endtask

    task automatic test_overrun();
        clear_mon();
        bus.rx_ready = 1'b0;
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'hC3, 1'b1, 1'b0);
        wait_clk(10);
        n_checks++; if (bus.rx_valid !== 1'b1) $display("FAIL overrun_held got %0b want 1", bus.rx_valid); else n_pass++;
        n_checks++; if (bus.rx_data !== 8'h3C) $display("FAIL overrun_data got %02h want 3c", bus.rx_data); else n_pass++;
        n_checks++; if (n_over !== 1) $display("FAIL overrun_pulses got %0d want 1", n_over); else n_pass++;
        n_checks++; if (n_rise !== 1) $display("FAIL overrun_rises got %0d want 1", n_rise); else n_pass++;
        bus.rx_ready = 1'b1;
        wait_clk(1);
        bus.rx_ready = 1'b0;
        n_checks++; if (bus.rx_valid !== 1'b0) $display("FAIL overrun_drop_valid got %0b want 0", bus.rx_valid); else n_pass++;
        n_checks++; if (n_acc !== 1 || last_acc !== 8'h3C) $display("FAIL overrun_accept got %0d/%02h want 1/3c", n_acc, last_acc); else n_pass++;
    endtask

    task automatic test_frame_err();
        clear_mon();
        bus.rx_ready = 1'b1;
        send_byte(8'h55, 1'b0, 1'b0);
        rx_in = 1'b0;
        wait_clk(30);
        n_checks++; if (busy !== 1'b0) $display("FAIL frame_busy got %0b want 0", busy); else n_pass++;
        rx_in = 1'b1;
        wait_clk(20);
        n_checks++; if (n_frame !== 1) $display("FAIL frame_pulses got %0d want 1", n_frame); else n_pass++;
        n_checks++; if (n_rise !== 0) $display("FAIL frame_no_byte got %0d want 0", n_rise); else n_pass++;
        send_byte(8'h01, 1'b1, 1'b0);
        wait_clk(20);
        n_checks++; if (n_rise !== 1 || last_data !== 8'h01) $display("FAIL frame_recover got %0d/%02h want 1/01", n_rise, last_data); else n_pass++;
        n_checks++; if (n_frame !== 1 || n_over !== 0) $display("FAIL frame_err_total got %0d/%0d want 1/0", n_frame, n_over); else n_pass++;
    endtask

    task automatic test_glitch();
        clear_mon();
        rx_in = 1'b0;
        wait_clk(3);
        rx_in = 1'b1;
        wait_clk(30);
        n_checks++; if (n_busy > CPB / 2) $display("FAIL glitch_busy_len got %0d want <= %0d", n_busy, CPB / 2); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL glitch_busy got %0b want 0", busy); else n_pass++;
        n_checks++; if (n_rise !== 0) $display("FAIL glitch_byte got %0d want 0", n_rise); else n_pass++;
        n_checks++; if (n_frame + n_over + n_par !== 0) $display("FAIL glitch_errors got %0d want 0", n_frame + n_over + n_par); else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_mon();
        bus.rx_ready = 1'b1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx_in = 1'b0;
        wait_clk(5);
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %0b want 0", busy); else n_pass++;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(25);
        rx_in = 1'b1;
        wait_clk(20);
        n_checks++; if (n_rise !== 0) $display("FAIL rstmid_spurious got %0d want 0", n_rise); else n_pass++;
        n_checks++; if (n_frame + n_over + n_par !== 0) $display("FAIL rstmid_errors got %0d want 0", n_frame + n_over + n_par); else n_pass++;
        send_byte(8'h81, 1'b1, 1'b0);
        wait_clk(20);
        n_checks++; if (n_rise !== 1 || last_data !== 8'h81) $display("FAIL rstmid_recover got %0d/%02h want 1/81", n_rise, last_data); else n_pass++;
    endtask

    task automatic test_parity();
        clear_mon();
        bus.rx_ready = 1'b1;
        send_byte(8'h07, 1'b1, 1'b1);
        wait_clk(20);
        n_checks++; if (n_rise !== 1 || last_data !== 8'h07) $display("FAIL parity_byte got %0d/%02h want 1/07", n_rise, last_data); else n_pass++;
`ifdef UART_RX_PARITY_EN
        n_checks++; if (n_par !== 1) $display("FAIL parity_pulses got %0d want 1", n_par); else n_pass++;
        n_checks++; if (n_par_v !== 1) $display("FAIL parity_with_valid got %0d want 1", n_par_v); else n_pass++;
`else
        n_checks++; if (n_par_all !== 0) $display("FAIL parity_tied got %0d want 0", n_par_all); else n_pass++;
`endif
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        clear_mon();
        test_reset();
        test_single();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_parity();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
